sm_divide_unit: RTL and testbench

//  Inverse of the sign-magnitude multiply-add datapath (Z = A*B + C): takes a 2N-bit

---
 rtl/sm_divide_unit.sv | 125 ++++++++++++
 tb/tb_sm_divide_unit.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/sm_divide_unit.sv
// Sign-magnitude restoring divider: Z (M-bit) / B (N-bit) -> Q, R (N-bit each).
// One quotient bit per cycle, valid/ready handshakes on both sides.
// Truncating semantics: sign(Q) = sZ^sB, sign(R) = sZ, and a zero magnitude never carries a sign.
module sm_divide_unit #(
  parameter int N = 8,
  parameter int M = 2 * N
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [M-1:0] Z,
  input  logic [N-1:0] B,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] Q,
  output logic [N-1:0] R,
  output logic         div_by_zero,
  output logic         overflow
);

  localparam int CW = (N > 2) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

  state_t        state;
  logic [N-2:0]  bm;      // |B|
  logic [N-2:0]  z_lo;    // low dividend bits, consumed MSB first
  logic [N-2:0]  p;       // partial remainder, always < |B|
  logic [N-2:0]  qm;      // quotient magnitude being built
  logic [CW-1:0] cnt;     // index of the next dividend bit
  logic          sz, sb;

  logic [M-2:0]  zm;
  logic [N-2:0]  bin;
  logic [N-1:0]  p_sh;
  logic          q_bit;
  logic [N-2:0]  p_nx;
  logic [N-1:0]  qw;
  logic [N-2:0]  qm_nx;

  assign zm       = Z[M-2:0];
  assign bin      = B[N-2:0];
  assign in_ready = (state == IDLE);

  // One restoring step: bring in the next dividend bit, subtract |B| if it fits.
  // The shifted value is N bits wide so the compare never loses a carry.
  always_comb begin
    p_sh  = {p, z_lo[cnt]};
    q_bit = (p_sh >= {1'b0, bm});
    p_nx  = q_bit ? (N-1)'(p_sh - {1'b0, bm}) : p_sh[N-2:0];
    qw    = {qm, q_bit};
    qm_nx = qw[N-2:0];
  end

  // Control FSM with registered result outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      bm          <= '0;
      z_lo        <= '0;
      p           <= '0;
      qm          <= '0;
      cnt         <= '0;
      sz          <= 1'b0;
      sb          <= 1'b0;
      out_valid   <= 1'b0;
      Q           <= '0;
      R           <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sz   <= Z[M-1];
            sb   <= B[N-1];
            bm   <= bin;
            z_lo <= zm[N-2:0];
            // Upper dividend half is the starting remainder; it is < |B| whenever we divide.
            p    <= (N-1)'(zm[M-2:N-1]);
            qm   <= '0;
            cnt  <= CW'(N - 2);
            if (bin == '0) begin
              state       <= DONE;
              out_valid   <= 1'b1;
              div_by_zero <= 1'b1;
              Q           <= '0;
              R           <= '0;
            end else if (M'(zm[M-2:N-1]) >= M'(bin)) begin
              state     <= DONE;
              out_valid <= 1'b1;
              overflow  <= 1'b1;
              Q         <= '0;
              R         <= '0;
            end else begin
              state <= DIV;
            end
          end
        end
        DIV: begin
          p   <= p_nx;
          qm  <= qm_nx;
          cnt <= cnt - 1'b1;
          if (cnt == '0) begin
            state     <= DONE;
            out_valid <= 1'b1;
            Q         <= {(sz ^ sb) & (|qm_nx), qm_nx};
            R         <= {sz & (|p_nx), p_nx};
          end
        end
        DONE: begin
          if (out_ready) begin
            state       <= IDLE;
            out_valid   <= 1'b0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sm_divide_unit.sv
// Bench for sm_divide_unit (N=8): arithmetic reference model, per-cycle compare
// of handshake/result outputs, directed corner cases plus random operands.
module tb_sm_divide_unit;
  localparam int N = 8;
  localparam int M = 16;

  logic         clk = 0, reset = 1;
  logic         in_valid = 0, out_ready = 1;
  logic [M-1:0] Z = '0;
  logic [N-1:0] B = '0;
  logic         in_ready, out_valid, div_by_zero, overflow;
  logic [N-1:0] Q, R;

  sm_divide_unit #(.N(N), .M(M)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .Z(Z), .B(B), .out_valid(out_valid), .out_ready(out_ready),
    .Q(Q), .R(R), .div_by_zero(div_by_zero), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [N-1:0] q, r;
    logic dbz, ovf;
    int   lat;
  } exp_t;

  // Truncating sign-magnitude division straight from the arithmetic definition.
  function automatic exp_t model(input logic [M-1:0] z, input logic [N-1:0] b);
    exp_t e;
    int zmag, bmag, qmag, rmag;
    zmag = int'(z[M-2:0]);
    bmag = int'(b[N-2:0]);
    e.q = '0; e.r = '0; e.dbz = 0; e.ovf = 0; e.lat = 1;
    if (bmag == 0) e.dbz = 1;
    else if (zmag / bmag > (1 << (N-1)) - 1) e.ovf = 1;
    else begin
      qmag  = zmag / bmag;
      rmag  = zmag % bmag;
      e.q   = {(z[M-1] ^ b[N-1]) && qmag != 0, 7'(qmag)};
      e.r   = {z[M-1] && rmag != 0, 7'(rmag)};
      e.lat = N;
    end
    return e;
  endfunction

  // Monitor: one operation in flight at most; compare every cycle on the falling edge.
  logic mon_en = 0;
  logic busy = 0;
  exp_t cur;
  int   cyc = 0, t0 = 0;

  always @(negedge clk) begin
    logic exp_ov;
    cyc++;
    exp_ov = busy && (cyc - t0 >= cur.lat);
    if (mon_en) begin
      chk("in_ready", in_ready, !busy);
      chk("out_valid", out_valid, exp_ov);
      if (exp_ov && out_valid) begin
        chk("Q", Q, cur.q);
        chk("R", R, cur.r);
        chk("div_by_zero", div_by_zero, cur.dbz);
        chk("overflow", overflow, cur.ovf);
      end
    end
    if (reset) busy = 0;
    else if (busy && exp_ov && out_ready) busy = 0;
    else if (!busy && in_valid) begin
      busy = 1;
      cur  = model(Z, B);
      t0   = cyc;
    end
  end

  // Random ready generator when enabled.
  logic rand_ready = 0;
  always @(posedge clk) begin
    #1;
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
  end

  // Offer an operand pair until accepted (bounded).
  task automatic do_op(input logic [M-1:0] z, input logic [N-1:0] b);
    logic acc;
    int   tries;
    tries = 0;
    in_valid = 1; Z = z; B = b;
    do begin
      @(negedge clk); acc = in_ready;
      @(posedge clk); #1;
      tries++;
    end while (!acc && tries < 200);
    if (!acc) chk("accept_timeout", 0, 1);
    in_valid = 0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (busy && t < 200) begin @(posedge clk); #1; t++; end
    if (busy) chk("idle_timeout", 0, 1);
  endtask

  task automatic run(input logic [M-1:0] z, input logic [N-1:0] b);
    do_op(z, b);
    wait_idle();
  endtask

  typedef struct {
    logic [M-1:0] z; logic [N-1:0] b;
    logic [N-1:0] q, r; logic dbz, ovf;
  } vec_t;

  vec_t vecs[7];

  initial begin
    exp_t e;
    vecs[0] = '{16'h0064, 8'h07, 8'h0E, 8'h02, 0, 0};
    vecs[1] = '{16'h8064, 8'h07, 8'h8E, 8'h82, 0, 0};
    vecs[2] = '{16'h0064, 8'h87, 8'h8E, 8'h02, 0, 0};
    vecs[3] = '{16'h3F7F, 8'h7F, 8'h7F, 8'h7E, 0, 0};
    vecs[4] = '{16'h8003, 8'h05, 8'h00, 8'h83, 0, 0};
    vecs[5] = '{16'h0010, 8'h80, 8'h00, 8'h00, 1, 0};
    vecs[6] = '{16'h4E20, 8'h07, 8'h00, 8'h00, 0, 1};

    // Pin the reference model with hand-computed results.
    foreach (vecs[i]) begin
      e = model(vecs[i].z, vecs[i].b);
      chk("model_q", e.q, vecs[i].q);
      chk("model_r", e.r, vecs[i].r);
      chk("model_flags", {e.dbz, e.ovf}, {vecs[i].dbz, vecs[i].ovf});
    end

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_Q", Q, 0);
    chk("rst_R", R, 0);
    chk("rst_flags", {div_by_zero, overflow}, 0);
    mon_en = 1;
    @(posedge clk); #1;
    reset = 0;

    // Directed vectors through the DUT (latency checked by the monitor).
    foreach (vecs[i]) run(vecs[i].z, vecs[i].b);

    // Backpressure: result held, new offer refused until released.
    out_ready = 0;
    do_op(16'h0064, 8'h07);
    begin
      int t;
      t = 0;
      while (!out_valid && t < 50) begin @(posedge clk); #1; t++; end
      if (!out_valid) chk("bp_timeout", 0, 1);
    end
    in_valid = 1; Z = 16'h8064; B = 8'h07;
    repeat (5) begin @(posedge clk); #1; end
    out_ready = 1;
    run(16'h8064, 8'h07);

    // Reset mid-DIV: sampled at edge k+3, no stale result afterwards.
    do_op(16'h0064, 8'h07);
    repeat (2) begin @(posedge clk); #1; end
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    @(negedge clk);
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_Q", Q, 0);
    chk("mid_rst_R", R, 0);
    repeat (10) begin @(posedge clk); #1; end
    run(16'h0064, 8'h07);

    // Random operands with random output backpressure.
    rand_ready = 1;
    for (int i = 0; i < 300; i++) begin
      logic [M-1:0] z;
      logic [N-1:0] b;
      int bmag;
      bmag = $urandom_range(0, 127);
      if ($urandom_range(0, 15) == 0) bmag = 0;
      b = {1'($urandom_range(0, 1)), 7'(bmag)};
      if (bmag != 0 && $urandom_range(0, 3) != 0)
        z = {1'($urandom_range(0, 1)), 15'($urandom_range(0, bmag * 128 - 1))};
      else
        z = 16'($urandom);
      do_op(z, b);
      if ($urandom_range(0, 1) == 0) wait_idle();
    end
    wait_idle();
    rand_ready = 0;
    out_ready = 1;
    repeat (3) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
